// File: rtl/dmem_ctrl_if.sv
// Data-bus bundle between dmem_ctrl (master) and the memory side (slave).
// Request channel is valid/ready; response is a valid-only ack/read return.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, we, addr, wdata, wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, we, addr, wdata, wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: one bus transaction per LSU access,
// stalling the pipeline until ack, with error and timeout reporting.
module dmem_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic        i_req_wr_en,
    input  logic [31:0] i_req_bit_wr_en,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wr_data,
    output logic        o_stall,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_bus_err,
    dmem_ctrl_if.master bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic          r_we;
    logic          r_err;
    logic [1:0]    r_off;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [3:0]    r_wstrb;
    logic [CW-1:0] r_cnt;

    logic        w_start;
    logic        w_cap;
    logic        w_abort;
    logic        w_to;
    logic        w_busy;
    logic [3:0]  w_wstrb;
    logic [31:0] w_shift;

    // Counter saturates at LIMIT, so reaching it means the budget is spent
    assign w_to    = TO_EN && (r_cnt == LIMIT);
    assign w_busy  = (r_state == S_REQ) || (r_state == S_RESP);
    assign w_shift = bus.rsp_rdata >> {r_off, 3'b000};

    always_comb begin
        w_wstrb = '0;
        for (int i = 0; i < 4; i++) begin
            w_wstrb[i] = |i_req_bit_wr_en[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A handshake or response in the last budgeted cycle beats the timeout
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_cap   = 1'b0;
        w_abort = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_next  = S_REQ;
                    w_start = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.req_ready) begin
                    w_next = S_RESP;
                end else if (w_to) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_valid) begin
                    w_next = S_DONE;
                    w_cap  = 1'b1;
                end else if (w_to) begin
                    w_next  = S_DONE;
                    w_abort = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_off   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_we    <= i_req_wr_en;
                r_err   <= 1'b0;
                r_off   <= i_req_addr[1:0];
                r_addr  <= {i_req_addr[31:2], 2'b00};
                r_wdata <= i_req_wr_data;
                r_wstrb <= w_wstrb;
            end
            if (w_cap) begin
                r_err <= bus.rsp_err;
                if (!r_we) begin
                    r_rdata <= w_shift;
                end
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (w_busy && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_stall    = i_req_valid && (r_state != S_DONE);
    assign o_rd_data  = r_rdata;
    assign o_rd_valid = (r_state == S_DONE) && !r_we && !r_err;
    assign o_bus_err  = (r_state == S_DONE) && r_err;

    assign bus.req_valid = (r_state == S_REQ);
    assign bus.we        = r_we;
    assign bus.addr      = r_addr;
    assign bus.wdata     = r_wdata;
    assign bus.wstrb     = r_wstrb;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: queued expectations from a transaction-level
// model, checked by a bus-side slave/monitor and a completion monitor.
module tb_dmem_ctrl;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr_en = 1'b0;
    logic [31:0] req_mask = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall;
    logic        rd_valid;
    logic        bus_err;
    logic [31:0] rd_data;

    dmem_ctrl_if bus();

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_req_valid     (req_valid),
        .i_req_wr_en     (req_wr_en),
        .i_req_bit_wr_en (req_mask),
        .i_req_addr      (req_addr),
        .i_req_wr_data   (req_wdata),
        .o_stall         (stall),
        .o_rd_data       (rd_data),
        .o_rd_valid      (rd_valid),
        .o_bus_err       (bus_err),
        .bus             (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } breq_t;

    typedef struct packed {
        logic        rv;
        logic        be;
        logic [31:0] rd;
    } rsp_t;

    breq_t bq[$];
    rsp_t  rq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rise = 0;
    int last_done = 0;
    int n_done = 0;

    int          cfg_rdly = 0;
    int          cfg_sdly = 0;
    logic [31:0] cfg_rdata = '0;
    bit          cfg_err = 1'b0;
    bit          cfg_noready = 1'b0;

    logic [31:0] model_rd = '0;

    bit in_req = 1'b0;
    bit pend = 1'b0;
    int rw = 0;
    int sw = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", nm);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_req_valid"}, 32'(bus.req_valid), 32'd0);
        chk({tag, "_we"}, 32'(bus.we), 32'd0);
        chk({tag, "_addr"}, bus.addr, 32'd0);
        chk({tag, "_wdata"}, bus.wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(bus.wstrb), 32'd0);
    endtask

    // Memory-side slave plus request-field monitor
    initial begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            bus.req_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_err   = 1'b0;
            bus.rsp_rdata = $urandom;
            if (bus.req_valid) begin
                if (!in_req) last_rise = cyc;
                if (bq.size() == 0) begin
                    fail("bus_req_unexpected");
                end else begin
                    chk("bus_we", 32'(bus.we), 32'(bq[0].we));
                    chk("bus_addr", bus.addr, bq[0].addr);
                    chk("bus_wdata", bus.wdata, bq[0].wdata);
                    chk("bus_wstrb", 32'(bus.wstrb), 32'(bq[0].wstrb));
                end
                in_req = 1'b1;
            end else if (in_req) begin
                in_req = 1'b0;
                if (bq.size() > 0) void'(bq.pop_front());
            end
            if (pend) begin
                if (sw == cfg_sdly) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = cfg_rdata;
                    bus.rsp_err   = cfg_err;
                    pend = 1'b0;
                end else begin
                    sw++;
                end
            end else if (bus.req_valid && !cfg_noready) begin
                if (rw == cfg_rdly) begin
                    bus.req_ready = 1'b1;
                    pend = 1'b1;
                    sw = 0;
                    rw = 0;
                end else begin
                    rw++;
                end
            end
            if (!bus.req_valid) rw = 0;
        end
    end

    // Completion monitor: the stall-free cycle of a held request is DONE
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && req_valid && !stall) begin
                last_done = cyc;
                n_done++;
                if (rq.size() == 0) begin
                    fail("done_unexpected");
                end else begin
                    e = rq.pop_front();
                    chk("rd_valid", 32'(rd_valid), 32'(e.rv));
                    chk("bus_err", 32'(bus_err), 32'(e.be));
                    chk("rd_data", rd_data, e.rd);
                    chk("req_valid_in_done", 32'(bus.req_valid), 32'd0);
                end
            end else if (rd_valid || bus_err) begin
                fail("spurious_pulse");
            end
        end
    end

    task automatic access(input bit we, input logic [31:0] a,
                          input logic [31:0] m, input logic [31:0] d,
                          input int rdly, input int sdly,
                          input logic [31:0] rdata, input bit err,
                          input bit noready);
        int stalls;
        int exp_st;
        logic [3:0] sb;
        for (int i = 0; i < 4; i++) sb[i] = (m[8*i +: 8] != 8'h00);
        bq.push_back(breq_t'{we: we, addr: a & ~32'h3, wdata: d, wstrb: sb});
        if (noready) begin
            rq.push_back(rsp_t'{rv: 1'b0, be: 1'b1, rd: model_rd});
            exp_st = 1 + TO;
        end else begin
            if (!we) model_rd = rdata >> (8 * int'(a[1:0]));
            rq.push_back(rsp_t'{rv: !we && !err, be: err, rd: model_rd});
            exp_st = 3 + rdly + sdly;
        end
        cfg_rdly    = rdly;
        cfg_sdly    = sdly;
        cfg_rdata   = rdata;
        cfg_err     = err;
        cfg_noready = noready;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_wr_en = we;
        req_addr  = a;
        req_mask  = m;
        req_wdata = d;
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (stall) stalls++;
            else break;
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_st));
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int nd;
        bit we;
        logic [31:0] m;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        access(1'b0, 32'h1003, 32'h0, 32'h0, 0, 0, 32'hAABBCCDD, 1'b0, 1'b0);
        idle(1);
        access(1'b1, 32'h2000, 32'h00FF0000, 32'h00560000, 4, 0, 32'h0,
               1'b0, 1'b0);
        idle(1);
        access(1'b0, 32'h3001, 32'h0, 32'h0, 1, 2, 32'h12345678, 1'b1, 1'b0);
        idle(1);
        access(1'b0, 32'h4000, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1);
        idle(1);
        access(1'b1, 32'h5004, 32'h0, 32'hCAFEF00D, 0, 1, 32'h0, 1'b0, 1'b0);
        idle(1);

        // Reset while waiting in RESP; the slave's pending ack lands later
        bq.push_back(breq_t'{we: 1'b0, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0});
        cfg_rdly = 0;
        cfg_sdly = 4;
        cfg_rdata = 32'hDEADBEEF;
        cfg_err = 1'b0;
        cfg_noready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_wr_en = 1'b0;
        req_addr  = 32'h40;
        req_mask  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        model_rd = '0;
        #1;
        chk_reset_outputs("midreset");
        nd = n_done;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("stray_rsp_done", 32'(n_done), 32'(nd));
        chk("stray_rsp_rd_data", rd_data, 32'd0);

        access(1'b0, 32'h0002, 32'h0, 32'h0, 0, 0, 32'h11223344, 1'b0, 1'b0);
        d0 = last_done;
        access(1'b1, 32'h0008, 32'hFFFFFFFF, 32'h55AA55AA, 0, 0, 32'h0,
               1'b0, 1'b0);
        chk("b2b_req_rise", 32'(last_rise - d0), 32'd2);
        idle(1);

        access(1'b0, 32'h6003, 32'h0, 32'h0, 3, 3, 32'h80706050, 1'b0, 1'b0);
        idle(1);

        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom % 2);
            m = '0;
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom % 2 == 1) m[8*b +: 8] = 8'hFF;
                end
            end
            access(we, $urandom, m, $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom,
                   ($urandom % 8) == 0, ($urandom % 10) == 0);
            if ($urandom % 2 == 1) idle(int'($urandom_range(0, 2)));
        end
        idle(5);
        chk("bus_queue_drained", 32'(bq.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
